rank_cmd_dispatcher: RTL and testbench

Sits between the host-side command source and the per-rank DRAM controllers. Accepts one `user_command_type_t` per cycle over a valid/ready handshake and sorts it by `rank_num` into one of four per-rank FIFOs. Each FIFO presents a `command_t`, with the rank field stripped, to its rank controller over an independent valid/ready handshake. Command order is preserved within each rank; there is no ordering guarantee across ranks.

---
 rtl/rank_cmd_dispatcher.sv | 158 +++++++++++++++
 tb/tb_rank_cmd_dispatcher.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rank_cmd_dispatcher.sv
// rank_cmd_dispatcher: sorts incoming user commands by rank into four
// independent FIFOs and presents each FIFO head (rank field stripped) to its
// rank controller over a valid/ready handshake.
module rank_cmd_dispatcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1,
    // Packed widths of command_t and user_command_type_t (fixed layout).
    localparam int CMD_W     = 37,
    localparam int UCMD_W    = CMD_W + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [UCMD_W-1:0]    in_cmd,
    input  logic [3:0]           rank_en,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*CMD_W-1:0]   out_cmd,
    output logic [4*CNT_W-1:0]   fifo_cnt,
    output logic                 drop_err,
    output logic                 idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Command as delivered to a rank controller, MSB first.
    typedef struct packed {
        logic        r_w;
        logic [2:0]  none_0;
        logic [13:0] row_addr;
        logic [1:0]  none_1;
        logic [1:0]  burst_length;
        logic        none_2;
        logic        auto_precharge;
        logic [9:0]  col_addr;
        logic [2:0]  bank_addr;
    } command_t;

    // Host-side command: the rank selector sits above the controller fields.
    typedef struct packed {
        logic [1:0]  rank_num;
        logic        r_w;
        logic [2:0]  none_0;
        logic [13:0] row_addr;
        logic [1:0]  none_1;
        logic [1:0]  burst_length;
        logic        none_2;
        logic        auto_precharge;
        logic [9:0]  col_addr;
        logic [2:0]  bank_addr;
    } user_command_type_t;

    user_command_type_t   in_u;
    command_t             in_c;
    logic [1:0]           in_rank;

    command_t             mem    [4][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr [4];
    logic [PTR_W-1:0]     rd_ptr [4];
    logic [CNT_W-1:0]     cnt    [4];

    logic [3:0]           full;
    logic [3:0]           push;
    logic [3:0]           pop;
    logic                 xfer;
    logic                 drop;

    assign in_u    = in_cmd;
    assign in_rank = in_u.rank_num;

    // Strip the rank selector; every controller field is copied bit-exact.
    always_comb begin
        in_c                = '0;
        in_c.r_w            = in_u.r_w;
        in_c.none_0         = in_u.none_0;
        in_c.row_addr       = in_u.row_addr;
        in_c.none_1         = in_u.none_1;
        in_c.burst_length   = in_u.burst_length;
        in_c.none_2         = in_u.none_2;
        in_c.auto_precharge = in_u.auto_precharge;
        in_c.col_addr       = in_u.col_addr;
        in_c.bank_addr      = in_u.bank_addr;
    end

    // Per-rank status flags plus the input/output handshake decode.
    // in_ready deliberately ignores out_ready: a full FIFO never accepts,
    // even when it is being popped in the same cycle.
    always_comb begin
        full      = '0;
        out_valid = '0;
        push      = '0;
        pop       = '0;
        for (int r = 0; r < 4; r++) begin
            full[r]      = (cnt[r] == CNT_W'(FIFO_DEPTH));
            out_valid[r] = (cnt[r] != '0);
        end
        in_ready = !rank_en[in_rank] || !full[in_rank];
        xfer     = in_valid && in_ready;
        drop     = xfer && !rank_en[in_rank];
        for (int r = 0; r < 4; r++) begin
            push[r] = xfer && rank_en[r] && (in_rank == 2'(r));
            pop[r]  = out_valid[r] && out_ready[r];
        end
    end

    // Pointer, occupancy and drop-pulse state; reset discards queued entries
    // and ignores any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 4; r++) begin
                wr_ptr[r] <= '0;
                rd_ptr[r] <= '0;
                cnt[r]    <= '0;
            end
            drop_err <= 1'b0;
        end else begin
            for (int r = 0; r < 4; r++) begin
                if (push[r]) begin
                    wr_ptr[r] <= wr_ptr[r] + PTR_W'(1);
                end
                if (pop[r]) begin
                    rd_ptr[r] <= rd_ptr[r] + PTR_W'(1);
                end
                case ({push[r], pop[r]})
                    2'b10:   cnt[r] <= cnt[r] + CNT_W'(1);
                    2'b01:   cnt[r] <= cnt[r] - CNT_W'(1);
                    default: cnt[r] <= cnt[r];
                endcase
            end
            drop_err <= drop;
        end
    end

    // Entry storage is data only and is never cleared; pointers gate its use.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 4; r++) begin
            if (push[r]) begin
                mem[r][wr_ptr[r]] <= in_c;
            end
        end
    end

    // Flatten per-rank heads and counts onto the output buses.
    always_comb begin
        out_cmd  = '0;
        fifo_cnt = '0;
        idle     = 1'b1;
        for (int r = 0; r < 4; r++) begin
            out_cmd[r*CMD_W +: CMD_W]  = mem[r][rd_ptr[r]];
            fifo_cnt[r*CNT_W +: CNT_W] = cnt[r];
            if (cnt[r] != '0) begin
                idle = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rank_cmd_dispatcher.sv
// Testbench for rank_cmd_dispatcher: directed table, multi-cycle corner
// sequences and a randomized run against a queue-based reference model.
module tb_rank_cmd_dispatcher;

    localparam int DEPTH  = 4;
    localparam int CW     = 3;
    localparam int CMD_W  = 37;
    localparam int UCMD_W = 39;
    localparam logic       WRITE = 1'b1;
    localparam logic [1:0] BL_8  = 2'd2;

    typedef struct packed {
        logic        r_w;
        logic [2:0]  none_0;
        logic [13:0] row_addr;
        logic [1:0]  none_1;
        logic [1:0]  burst_length;
        logic        none_2;
        logic        auto_precharge;
        logic [9:0]  col_addr;
        logic [2:0]  bank_addr;
    } command_t;

    typedef struct packed {
        logic [1:0]  rank_num;
        logic        r_w;
        logic [2:0]  none_0;
        logic [13:0] row_addr;
        logic [1:0]  none_1;
        logic [1:0]  burst_length;
        logic        none_2;
        logic        auto_precharge;
        logic [9:0]  col_addr;
        logic [2:0]  bank_addr;
    } user_command_type_t;

    typedef struct {
        logic [3:0]      en;
        logic            v;
        logic [1:0]      rk;
        logic [3:0]      ordy;
        logic            exp_rdy;
        logic [3:0]      exp_ov;
        logic [4*CW-1:0] exp_cnt;
        logic            exp_drop;
        logic            exp_idle;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [UCMD_W-1:0]    in_cmd;
    logic [3:0]           rank_en;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [4*CMD_W-1:0]   out_cmd;
    logic [4*CW-1:0]      fifo_cnt;
    logic                 drop_err;
    logic                 idle;

    int total = 0;
    int bad   = 0;

    vec_t vecs [19];
    command_t model_q [4][$];

    rank_cmd_dispatcher #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_cmd   (in_cmd),
        .rank_en  (rank_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_cmd  (out_cmd),
        .fifo_cnt (fifo_cnt),
        .drop_err (drop_err),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic user_command_type_t mk(input logic [1:0] rk, input logic [9:0] col);
        user_command_type_t u;
        u                = '0;
        u.rank_num       = rk;
        u.r_w            = col[0];
        u.row_addr       = {4'h5, col};
        u.burst_length   = col[2:1];
        u.auto_precharge = col[3];
        u.col_addr       = col;
        u.bank_addr      = col[6:4];
        u.none_0         = col[9:7];
        return u;
    endfunction

    function automatic command_t strip(input user_command_type_t u);
        command_t c;
        c = {u.r_w, u.none_0, u.row_addr, u.none_1, u.burst_length,
             u.none_2, u.auto_precharge, u.col_addr, u.bank_addr};
        return c;
    endfunction

    function automatic logic [4*CW-1:0] pc(input int c0, input int c1, input int c2, input int c3);
        return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    endfunction

    function automatic logic [CW-1:0] get_cnt(input int r);
        return fifo_cnt[r*CW +: CW];
    endfunction

    function automatic logic [CMD_W-1:0] get_out(input int r);
        return out_cmd[r*CMD_W +: CMD_W];
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 4'h0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Directed cycle table, starting from an empty dispatcher.
        vecs[0]  = '{4'hF, 1'b1, 2'd1, 4'h0, 1'b1, 4'b0010, pc(0,1,0,0), 1'b0, 1'b0};
        vecs[1]  = '{4'hF, 1'b1, 2'd1, 4'h0, 1'b1, 4'b0010, pc(0,2,0,0), 1'b0, 1'b0};
        vecs[2]  = '{4'hF, 1'b1, 2'd1, 4'h0, 1'b1, 4'b0010, pc(0,3,0,0), 1'b0, 1'b0};
        vecs[3]  = '{4'hF, 1'b1, 2'd1, 4'h0, 1'b1, 4'b0010, pc(0,4,0,0), 1'b0, 1'b0};
        vecs[4]  = '{4'hF, 1'b1, 2'd1, 4'h0, 1'b0, 4'b0010, pc(0,4,0,0), 1'b0, 1'b0};
        vecs[5]  = '{4'hF, 1'b1, 2'd0, 4'h0, 1'b1, 4'b0011, pc(1,4,0,0), 1'b0, 1'b0};
        vecs[6]  = '{4'hF, 1'b1, 2'd1, 4'h2, 1'b0, 4'b0011, pc(1,3,0,0), 1'b0, 1'b0};
        vecs[7]  = '{4'hF, 1'b1, 2'd1, 4'h0, 1'b1, 4'b0011, pc(1,4,0,0), 1'b0, 1'b0};
        vecs[8]  = '{4'hE, 1'b1, 2'd0, 4'h0, 1'b1, 4'b0011, pc(1,4,0,0), 1'b1, 1'b0};
        vecs[9]  = '{4'hE, 1'b0, 2'd0, 4'h1, 1'b1, 4'b0010, pc(0,4,0,0), 1'b0, 1'b0};
        vecs[10] = '{4'hF, 1'b0, 2'd0, 4'h2, 1'b1, 4'b0010, pc(0,3,0,0), 1'b0, 1'b0};
        vecs[11] = '{4'hF, 1'b0, 2'd0, 4'h2, 1'b1, 4'b0010, pc(0,2,0,0), 1'b0, 1'b0};
        vecs[12] = '{4'hF, 1'b0, 2'd0, 4'h2, 1'b1, 4'b0010, pc(0,1,0,0), 1'b0, 1'b0};
        vecs[13] = '{4'hF, 1'b0, 2'd0, 4'h2, 1'b1, 4'b0000, pc(0,0,0,0), 1'b0, 1'b1};
        vecs[14] = '{4'hF, 1'b1, 2'd3, 4'hF, 1'b1, 4'b1000, pc(0,0,0,1), 1'b0, 1'b0};
        vecs[15] = '{4'hF, 1'b1, 2'd3, 4'h0, 1'b1, 4'b1000, pc(0,0,0,2), 1'b0, 1'b0};
        vecs[16] = '{4'h7, 1'b0, 2'd3, 4'h0, 1'b1, 4'b1000, pc(0,0,0,2), 1'b0, 1'b0};
        vecs[17] = '{4'h7, 1'b0, 2'd3, 4'h8, 1'b1, 4'b1000, pc(0,0,0,1), 1'b0, 1'b0};
        vecs[18] = '{4'h7, 1'b0, 2'd3, 4'h8, 1'b1, 4'b0000, pc(0,0,0,0), 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_cmd    = '0;
        rank_en   = 4'hF;
        out_ready = 4'h0;
        step();
        step();
        rst = 1'b0;
        chk("reset out_valid", out_valid, 4'h0);
        chk("reset fifo_cnt", fifo_cnt, '0);
        chk("reset drop_err", drop_err, 1'b0);
        chk("reset idle", idle, 1'b1);

        // Single write to rank 2 with exact fields.
        begin
            user_command_type_t u;
            command_t exp_c;
            u = '0;
            u.rank_num = 2'd2; u.r_w = WRITE; u.row_addr = 14'h12; u.col_addr = 10'h8;
            u.bank_addr = 3'd3; u.burst_length = BL_8; u.auto_precharge = 1'b1;
            exp_c = '0;
            exp_c.r_w = WRITE; exp_c.row_addr = 14'h12; exp_c.col_addr = 10'h8;
            exp_c.bank_addr = 3'd3; exp_c.burst_length = BL_8; exp_c.auto_precharge = 1'b1;
            in_cmd = u; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk("single out_valid", out_valid, 4'b0100);
            chk("single out_cmd2", get_out(2), exp_c);
            chk("single cnt2", get_cnt(2), 3'd1);
            chk("single idle", idle, 1'b0);
            out_ready = 4'b0100;
            step();
            out_ready = 4'h0;
            chk("single pop cnt2", get_cnt(2), 3'd0);
            chk("single pop idle", idle, 1'b1);
        end

        // Directed table.
        for (int i = 0; i < 19; i++) begin
            rank_en   = vecs[i].en;
            in_valid  = vecs[i].v;
            in_cmd    = mk(vecs[i].rk, 10'(i));
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].exp_rdy);
            step();
            chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].exp_ov);
            chk($sformatf("vec%0d fifo_cnt", i), fifo_cnt, vecs[i].exp_cnt);
            chk($sformatf("vec%0d drop_err", i), drop_err, vecs[i].exp_drop);
            chk($sformatf("vec%0d idle", i), idle, vecs[i].exp_idle);
        end
        in_valid  = 1'b0;
        out_ready = 4'h0;
        rank_en   = 4'hF;

        // Order across pointer wrap: 10 commands through rank 1.
        begin
            int sent = 0;
            int popped = 0;
            for (int cyc = 0; cyc < 40 && popped < 10; cyc++) begin
                in_valid  = (sent < 10);
                in_cmd    = mk(2'd1, 10'(100 + sent));
                out_ready = (cyc % 3 != 0) ? 4'b0010 : 4'b0000;
                #1;
                if (out_valid[1] && out_ready[1]) begin
                    command_t h;
                    h = get_out(1);
                    chk($sformatf("wrap pop%0d col", popped), h.col_addr, 10'(100 + popped));
                    popped++;
                end
                if (in_valid && in_ready) sent++;
                step();
            end
            chk("wrap pop count", popped, 10);
            in_valid  = 1'b0;
            out_ready = 4'h0;
        end

        // Concurrent pops: one entry in every rank, all drained in one cycle.
        for (int r = 0; r < 4; r++) begin
            in_valid = 1'b1;
            in_cmd   = mk(2'(r), 10'(200 + r));
            step();
        end
        in_valid = 1'b0;
        chk("concurrent fill cnt", fifo_cnt, pc(1,1,1,1));
        out_ready = 4'hF;
        step();
        out_ready = 4'h0;
        chk("concurrent cnt", fifo_cnt, pc(0,0,0,0));
        chk("concurrent idle", idle, 1'b1);

        // Disabled rank 3 still delivers its queued entries.
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_cmd   = mk(2'd3, 10'(300 + k));
            step();
        end
        in_valid = 1'b0;
        rank_en  = 4'b0111;
        for (int k = 0; k < 2; k++) begin
            command_t h;
            out_ready = 4'b1000;
            #1;
            h = get_out(3);
            chk($sformatf("disabled deliver%0d valid", k), out_valid[3], 1'b1);
            chk($sformatf("disabled deliver%0d col", k), h.col_addr, 10'(300 + k));
            step();
        end
        out_ready = 4'h0;
        rank_en   = 4'hF;
        chk("disabled drained idle", idle, 1'b1);

        // Reset mid-stream with entries queued and a transfer offered.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_cmd   = mk(2'd2, 10'(400 + k));
            step();
        end
        chk("pre-reset cnt2", get_cnt(2), 3'd3);
        rst = 1'b1;
        in_cmd = mk(2'd2, 10'd403);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("midreset fifo_cnt", fifo_cnt, '0);
        chk("midreset out_valid", out_valid, 4'h0);
        chk("midreset drop_err", drop_err, 1'b0);
        chk("midreset idle", idle, 1'b1);
        step();
        chk("postreset out_valid", out_valid, 4'h0);

        // Randomized run against the queue model.
        for (int r = 0; r < 4; r++) model_q[r].delete();
        begin
            logic exp_drop = 1'b0;
            logic hold = 1'b0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                user_command_type_t u;
                logic [3:0] ov;
                logic [4*CW-1:0] ec;
                logic exp_rdy;
                int rk;
                rst = ($urandom_range(0, 199) == 0);
                if (cyc % 64 == 0) rank_en = 4'($urandom_range(0, 15)) | 4'b0001;
                if (!hold) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_cmd   = UCMD_W'({$urandom(), $urandom()});
                end
                out_ready = 4'($urandom_range(0, 15));
                #1;
                u  = in_cmd;
                rk = int'(u.rank_num);
                exp_rdy = !rank_en[rk] || (model_q[rk].size() < DEPTH);
                ov = '0;
                ec = '0;
                for (int r = 0; r < 4; r++) begin
                    ov[r] = (model_q[r].size() > 0);
                    ec[r*CW +: CW] = CW'(model_q[r].size());
                end
                chk("rand in_ready", in_ready, exp_rdy);
                chk("rand out_valid", out_valid, ov);
                chk("rand fifo_cnt", fifo_cnt, ec);
                chk("rand idle", idle, (ov == 4'h0));
                chk("rand drop_err", drop_err, exp_drop);
                for (int r = 0; r < 4; r++) begin
                    if (ov[r]) chk($sformatf("rand head%0d", r), get_out(r), model_q[r][0]);
                end
                hold = in_valid && !exp_rdy && !rst;
                if (rst) begin
                    for (int r = 0; r < 4; r++) model_q[r].delete();
                    exp_drop = 1'b0;
                    hold = 1'b0;
                end else begin
                    for (int r = 0; r < 4; r++) begin
                        if (ov[r] && out_ready[r]) void'(model_q[r].pop_front());
                    end
                    exp_drop = in_valid && exp_rdy && !rank_en[rk];
                    if (in_valid && exp_rdy && rank_en[rk]) model_q[rk].push_back(strip(u));
                end
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
